// File: rtl/dmem_line_responder.sv
// Cache-line memory responder: accepts one line read/write request at a time,
// holds it for a fixed latency and completes it with a one-cycle ack pulse.
// Handshake: the requester raises enable_i with write_i/addr_i/data_i and keeps it
// high until it sees ack_o; the request is captured in the IDLE cycle it is seen,
// and everything on the inputs after that capture is ignored until the next IDLE.
module dmem_line_responder #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic [1:0]        state_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         cnt;
  logic [7:0]         cnt_nxt;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LINE_W-1:0]  wdata_q;
  logic [IDX_W-1:0]   req_idx;
  logic               rd_load;
  logic [IDX_W-1:0]   rd_idx;
  logic [LINE_W-1:0]  mem [DEPTH];
  logic               unused_addr;

  // Byte offset and index bits above the array size are dropped (line aligned, wrapping).
  assign req_idx     = addr_i[5 +: IDX_W];
  assign unused_addr = ^{addr_i[4:0], addr_i[ADDR_W-1:5+IDX_W]};

  assign ack_o   = (state == S_ACK);
  assign busy_o  = (state == S_WAIT);
  assign state_o = state;

  // State and latency counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: IDLE -> WAIT (counting down) -> ACK -> IDLE; LATENCY==1 skips WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (enable_i) begin
          cnt_nxt   = LAT_M1;
          state_nxt = (LATENCY > 1) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the request once, in the IDLE cycle it is accepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (state == S_IDLE && enable_i) begin
      wr_q    <= write_i;
      idx_q   <= req_idx;
      wdata_q <= data_i;
    end
  end

  // A read loads data_o on the edge entering ACK; with LATENCY==1 that edge is
  // the accepting edge itself, so the live request fields are used.
  always_comb begin
    rd_load = 1'b0;
    rd_idx  = idx_q;
    if (state == S_WAIT && cnt == 8'd1 && !wr_q) begin
      rd_load = 1'b1;
    end else if (LATENCY == 1 && state == S_IDLE && enable_i && !write_i) begin
      rd_load = 1'b1;
      rd_idx  = req_idx;
    end
  end

  // Read data register, held until the next read completes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) data_o <= '0;
    else if (rd_load) data_o <= mem[rd_idx];
  end

  // Writes commit at the end of the ACK cycle; reset before then drops them.
  always_ff @(posedge clk_i) begin
    if (state == S_ACK && wr_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: one instance at LATENCY=10, one at LATENCY=1.
module tb_dmem_line_responder;

  localparam logic [255:0] P_DB = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] P_L1 = {8{32'h1111_0001}};
  localparam logic [255:0] P_L2 = {8{32'h2222_0002}};
  localparam logic [255:0] P_L3 = {8{32'h3333_0003}};
  localparam logic [255:0] P_BAD = {8{32'hBAD0_0BAD}};
  localparam logic [255:0] P_L5 = {8{32'h5555_A5A5}};
  localparam logic [255:0] P_L6 = {8{32'h6666_C3C3}};
  localparam logic [255:0] P_WR = {8{32'h0123_4567}};
  localparam logic [255:0] P_U1 = {8{32'h89AB_CDEF}};

  logic         clk;
  logic         rst_n;
  logic         en, wr, ack, busy;
  logic [31:0]  addr;
  logic [255:0] wdata, rdata;
  logic [1:0]   st;
  logic         en1, wr1, ack1, busy1;
  logic [31:0]  addr1;
  logic [255:0] wdata1, rdata1;
  logic [1:0]   st1;
  logic         busy1_seen;

  int checks;
  int errors;
  logic [255:0] exp_q[$];

  dmem_line_responder #(.LATENCY(10)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en), .write_i(wr), .addr_i(addr),
    .data_i(wdata), .ack_o(ack), .data_o(rdata), .busy_o(busy), .state_o(st)
  );

  dmem_line_responder #(.LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
    .data_i(wdata1), .ack_o(ack1), .data_o(rdata1), .busy_o(busy1), .state_o(st1)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watch for any busy on the single-cycle instance
  initial busy1_seen = 1'b0;
  always @(negedge clk) if (busy1 === 1'b1) busy1_seen = 1'b1;

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for its ack; lat counts edges from the accepting edge (1-based).
  task automatic do_req(input bit sel, input bit w, input logic [31:0] a, input logic [255:0] d,
                        output int lat, output logic [255:0] rd);
    @(negedge clk);
    if (sel) begin en1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    else     begin en  = 1'b1; wr  = w; addr  = a; wdata  = d; end
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel ? ack1 : ack) begin
        lat = i;
        rd  = sel ? rdata1 : rdata;
        check_val("busy_in_ack", sel ? busy1 : busy, 1'b0);
        break;
      end
    end
    if (sel) en1 = 1'b0;
    else     en  = 1'b0;
  endtask

  initial begin
    int lat, cyc, last, nacks, b2b, acks;
    logic [255:0] rd;
    logic [31:0] b2b_addr [3];
    checks = 0; errors = 0;
    rst_n = 1'b0;
    en = 0; wr = 0; addr = '0; wdata = '0;
    en1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ack", ack, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_data", rdata, '0);
    check_val("rst_state", st, 2'd0);
    check_val("rst_ack1", ack1, 1'b0);
    check_val("rst_data1", rdata1, '0);
    rst_n = 1'b1;

    // Write then read, data_o untouched by the write
    do_req(0, 1, 32'h0000_0040, P_DB, lat, rd);
    check_val("wr_lat", lat, 10);
    check_val("wr_data_hold", rdata, '0);
    do_req(0, 0, 32'h0000_0040, '0, lat, rd);
    check_val("rd_lat", lat, 10);
    check_val("rd_data", rd, P_DB);

    // Back-to-back reads of lines 1,2,3
    do_req(0, 1, 32'h0000_0020, P_L1, lat, rd);
    do_req(0, 1, 32'h0000_0040, P_L2, lat, rd);
    do_req(0, 1, 32'h0000_0060, P_L3, lat, rd);
    check_val("wr_data_hold2", rdata, P_DB);
    exp_q.push_back(P_L1); exp_q.push_back(P_L2); exp_q.push_back(P_L3);
    b2b_addr[0] = 32'h20; b2b_addr[1] = 32'h40; b2b_addr[2] = 32'h60;
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = b2b_addr[0];
    cyc = 0; last = 0; nacks = 0; b2b = 0;
    for (int i = 0; i < 60; i++) begin
      logic prev;
      prev = ack;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (ack) begin
        if (prev) b2b++;
        if (nacks == 0) check_val("b2b_first_lat", cyc, 10);
        else            check_val("b2b_spacing", cyc - last, 11);
        check_val("b2b_data", rdata, exp_q.pop_front());
        last = cyc;
        nacks++;
        if (nacks < 3) addr = b2b_addr[nacks];
        else begin en = 1'b0; break; end
      end
    end
    en = 1'b0;
    check_val("b2b_count", nacks, 3);
    check_val("b2b_adjacent", b2b, 0);

    // Reset in the middle of a write to line 3
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h60; wdata = P_BAD;
    repeat (4) @(negedge clk);
    check_val("mid_wait_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("arst_ack", ack, 1'b0);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_state", st, 2'd0);
    check_val("arst_data", rdata, '0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check_val("arst_no_ack", acks, 0);
    do_req(0, 0, 32'h60, '0, lat, rd);
    check_val("arst_line3", rd, P_L3);

    // Input churn after acceptance
    do_req(0, 1, 32'hC0, P_L6, lat, rd);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'hA0; wdata = P_L5;
    @(posedge clk);
    acks = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ack) acks++;
      en    = 1'b0;
      wr    = ~wr;
      wdata = ~wdata;
      addr  = (i % 2 == 0) ? 32'hC0 : 32'h60;
    end
    check_val("churn_acks", acks, 1);
    do_req(0, 0, 32'hA0, '0, lat, rd);
    check_val("churn_line5", rd, P_L5);
    do_req(0, 0, 32'hC0, '0, lat, rd);
    check_val("churn_line6", rd, P_L6);
    do_req(0, 0, 32'h60, '0, lat, rd);
    check_val("churn_line3", rd, P_L3);

    // Alignment and index wrap
    do_req(0, 1, 32'h0000_401F, P_WR, lat, rd);
    check_val("wrap_wr_lat", lat, 10);
    do_req(0, 0, 32'h0000_0000, '0, lat, rd);
    check_val("wrap_line0", rd, P_WR);
    do_req(0, 0, 32'h0000_0020, '0, lat, rd);
    check_val("wrap_line1", rd, P_L1);

    // LATENCY=1 instance
    do_req(1, 1, 32'h40, P_U1, lat, rd);
    check_val("lat1_wr_lat", lat, 1);
    check_val("lat1_wr_hold", rdata1, '0);
    do_req(1, 0, 32'h40, '0, lat, rd);
    check_val("lat1_rd_lat", lat, 1);
    check_val("lat1_rd_data", rd, P_U1);
    repeat (2) @(negedge clk);
    check_val("lat1_never_busy", busy1_seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
